// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word when idle and enabled, sends it as a UART frame (start, LSB-first data, stop).
// Define FIFO_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    START,
    DATA,
`ifdef FIFO_TX_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;

  state_t                  state_q, state_n;
  logic [DIV_W-1:0]        div_q, div_n;
  logic [BIT_W-1:0]        bit_q, bit_n;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_n;
  logic                    tx_n;
  logic                    div_last;
`ifdef FIFO_TX_PARITY_EN
  logic                    par_q;
`endif

  assign div_last = (div_q == DIV_MAX);
  assign busy     = (state_q != IDLE) || fifo_rd;

  // Next-state logic; tx is derived from the next state so the registered line lines up with the state
  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    fifo_rd = 1'b0;
    done    = 1'b0;
    tx_n    = 1'b1;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          fifo_rd = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        shreg_n = fifo_data;
        div_n   = '0;
        bit_n   = '0;
        state_n = START;
      end
      START: begin
        if (div_last) begin
          div_n   = '0;
          state_n = DATA;
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      DATA: begin
        if (div_last) begin
          div_n = '0;
          if (bit_q == DATA_LAST) begin
            bit_n = '0;
`ifdef FIFO_TX_PARITY_EN
            state_n = PAR;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n   = bit_q + 1'b1;
            shreg_n = shreg_q >> 1;
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end
`ifdef FIFO_TX_PARITY_EN
      PAR: begin
        if (div_last) begin
          div_n   = '0;
          state_n = STOP;
        end else begin
          div_n = div_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (div_last) begin
          div_n = '0;
          if (bit_q == STOP_LAST) begin
            done    = 1'b1;
            bit_n   = '0;
            state_n = IDLE;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Reset wins over everything, so strobes are masked in the reset cycle itself
    if (reset) begin
      fifo_rd = 1'b0;
      done    = 1'b0;
    end

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
`ifdef FIFO_TX_PARITY_EN
      PAR:     tx_n = par_q;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      bit_q   <= bit_n;
      shreg_q <= shreg_n;
      tx      <= tx_n;
    end
  end

`ifdef FIFO_TX_PARITY_EN
  // Even parity is taken from the word as it arrives, since the shift register is consumed during DATA
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (state_q == REQ) begin
      par_q <= ^fifo_data;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with CLK_DIV=4, DATA_WIDTH=8, STOP_BITS=1.
// Observed outputs are packed as {fifo_rd, busy, done, tx}; cycle 0 is the fifo_rd cycle.
module tb_fifo_uart_tx;

  localparam int CD = 4;
  localparam int DW = 8;
  localparam int SB = 1;
`ifdef FIFO_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = 2 + CD * (2 + DW + PB + SB - 1);

  typedef struct {
    int         cyc;
    logic [3:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd, tx, busy, done;

  vec_t       tblA5[$];
  vec_t       tbl07[$];
  logic [7:0] q[$];
  logic       last_rd = 1'b0;
  int         checks = 0;
  int         errors = 0;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD), .STOP_BITS(SB)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd(fifo_rd),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual={rd,busy,done,tx}=%b expected=%b", name, k, act, exp);
    end
  endtask

  // Sample on the falling edge, then move past the rising edge and update the FIFO model
  task automatic step(output logic [3:0] obs);
    @(negedge clk);
    obs = {fifo_rd, busy, done, tx};
    last_rd = fifo_rd;
    @(posedge clk);
    #1;
    if (last_rd && q.size() > 0) fifo_data = q.pop_front();
    else fifo_data = 8'($urandom);
    fifo_empty = (q.size() == 0);
  endtask

  function automatic logic [3:0] exp_out(input logic [7:0] w, input int k);
    logic t;
    if (k >= FL) return 4'b0001;
    if (k < 2) t = 1'b1;
    else if (k < 2 + CD) t = 1'b0;
    else if (k < 2 + CD + CD * DW) t = w[(k - 2 - CD) / CD];
    else if (PB == 1 && k < 2 + CD * (2 + DW)) t = ^w;
    else t = 1'b1;
    return {(k == 0), 1'b1, (k == FL - 1), t};
  endfunction

  task automatic run_frame(input logic [7:0] w, input int sel, input int ncyc, input int drop_at);
    logic [3:0] obs;
    for (int k = 0; k < ncyc; k++) begin
      step(obs);
      check("frame", k, obs, exp_out(w, k));
      if (sel == 1) foreach (tblA5[i]) if (tblA5[i].cyc == k) check("vecA5", k, obs, tblA5[i].exp);
      if (sel == 2) foreach (tbl07[i]) if (tbl07[i].cyc == k) check("vec07", k, obs, tbl07[i].exp);
      if (k == drop_at) enable = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] obs;

    // Hand-computed checkpoints for 0xA5 (LSB first: 1,0,1,0,0,1,0,1)
    tblA5.push_back('{0, 4'b1101});  tblA5.push_back('{1, 4'b0101});
    tblA5.push_back('{2, 4'b0100});  tblA5.push_back('{5, 4'b0100});
    tblA5.push_back('{6, 4'b0101});  tblA5.push_back('{9, 4'b0101});
    tblA5.push_back('{10, 4'b0100}); tblA5.push_back('{14, 4'b0101});
    tblA5.push_back('{18, 4'b0100}); tblA5.push_back('{22, 4'b0100});
    tblA5.push_back('{26, 4'b0101}); tblA5.push_back('{30, 4'b0100});
    tblA5.push_back('{34, 4'b0101}); tblA5.push_back('{37, 4'b0101});
`ifdef FIFO_TX_PARITY_EN
    tblA5.push_back('{38, 4'b0100}); tblA5.push_back('{41, 4'b0100});
    tblA5.push_back('{42, 4'b0101}); tblA5.push_back('{45, 4'b0111});
    tblA5.push_back('{46, 4'b0001});
`else
    tblA5.push_back('{38, 4'b0101}); tblA5.push_back('{40, 4'b0101});
    tblA5.push_back('{41, 4'b0111}); tblA5.push_back('{42, 4'b0001});
`endif
    // 0x07 with parity: bit7=0, parity=1, stop 42-45, done at 45
    tbl07.push_back('{37, 4'b0100}); tbl07.push_back('{38, 4'b0101});
    tbl07.push_back('{41, 4'b0101}); tbl07.push_back('{42, 4'b0101});
    tbl07.push_back('{45, 4'b0111}); tbl07.push_back('{46, 4'b0001});

    // Reset held with a word waiting and enable high
    q.push_back(8'hA5);
    fifo_empty = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      step(obs);
      check("reset_hold", i, obs, 4'b0001);
    end
    reset = 1'b0;
    run_frame(8'hA5, 1, FL + 4, -1);

    // Back-to-back words
    q.push_back(8'h00);
    q.push_back(8'hFF);
    fifo_empty = 1'b0;
    run_frame(8'h00, 0, FL, -1);
    run_frame(8'hFF, 0, FL + 4, -1);

    // Disabled with data waiting, then enable dropped mid-frame
    enable = 1'b0;
    q.push_back(8'h3C);
    q.push_back(8'h99);
    fifo_empty = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(obs);
      check("no_pop_disabled", i, obs, 4'b0001);
    end
    enable = 1'b1;
    run_frame(8'h3C, 0, FL, 10);
    for (int i = 0; i < 20; i++) begin
      step(obs);
      check("no_pop_after_drop", i, obs, 4'b0001);
    end

    // Reset in the middle of DATA
    q.push_back(8'h5A);
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(obs);
      check("pre_reset", k, obs, exp_out(8'h99, k));
    end
    reset = 1'b1;
    step(obs);
    check("reset_cycle_rd", 20, {3'b000, obs[3]}, 4'b0000);
    for (int i = 21; i < 25; i++) begin
      step(obs);
      check("reset_mid", i, obs, 4'b0001);
    end
    reset = 1'b0;
    run_frame(8'h5A, 0, FL + 4, -1);

`ifdef FIFO_TX_PARITY_EN
    q.push_back(8'h07);
    fifo_empty = 1'b0;
    run_frame(8'h07, 2, FL + 4, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
